// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: assembles 16-bit instructions from a byte stream
// (low byte first), buffers them in a small FIFO and presents the head entry
// to the execute stage through a valid/ready handshake.
module inst_fetch_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [15:0] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [3:0]  count,
    output logic [7:0]  issued
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CountMax = 4'(DEPTH);

    typedef enum logic [0:0] {
        PhLo,
        PhHi
    } phase_e;

    phase_e          state_q, state_d;
    logic [7:0]      held_lo_q, held_lo_d;
    logic [15:0]     mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [3:0]      count_q, count_d;
    logic [7:0]      issued_q, issued_d;

    logic full;
    logic byte_xfer;
    logic push;
    logic pop;

    // Handshake decode and output drive. byte_ready only stalls when a high
    // byte would complete a word that has nowhere to go; a low byte can always
    // be parked in the holding register.
    always_comb begin
        full       = (count_q == CountMax);
        byte_ready = !((state_q == PhHi) && full);
        inst_valid = (count_q != 4'd0);
        byte_xfer  = byte_valid && byte_ready;
        push       = byte_xfer && (state_q == PhHi);
        pop        = inst_valid && inst_ready;
        inst       = mem_q[rd_ptr_q];
        count      = count_q;
        issued     = issued_q;
    end

    // Assembly FSM next state: alternate low/high byte on each accepted byte.
    always_comb begin
        state_d   = state_q;
        held_lo_d = held_lo_q;
        if (flush) begin
            state_d = PhLo;
        end else if (byte_xfer) begin
            unique case (state_q)
                PhLo: begin
                    held_lo_d = byte_in;
                    state_d   = PhHi;
                end
                PhHi: begin
                    state_d = PhLo;
                end
                default: begin
                    state_d = PhLo;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy next state; flush empties the queue.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 4'd0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Issue counter next state; an issue cancelled by flush is not counted.
    always_comb begin
        issued_d = issued_q;
        if (!flush && pop) begin
            issued_d = issued_q + 8'd1;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PhLo;
            held_lo_q <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= 4'd0;
            issued_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            held_lo_q <= held_lo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            issued_q  <= issued_d;
        end
    end

    // FIFO storage: written on a completed word, never reset.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_q[wr_ptr_q] <= {byte_in, held_lo_q};
        end
    end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Purpose: upstream stage of the processor core. It assembles 16-bit instructions from byte-wide input, buffers them, and issues them to the execute stage with a valid/ready handshake.

Interface
REQ-001 Parameter DEPTH, default 4, number of 16-bit instruction FIFO entries; power of two, 2..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  discard all buffered and partially assembled instructions.
REQ-005 byte_in  input  8  instruction byte; low byte first, then high byte.
REQ-006 byte_valid  input  1  byte_in is valid this cycle.
REQ-007 byte_ready  output  1  block accepts byte_in this cycle.
REQ-008 inst  output  16  head-of-queue instruction; [2:0] opcode, [6:3] func, [9:7] reg2, [12:10] reg1, [15:13] regw.
REQ-009 inst_valid  output  1  inst holds a valid instruction.
REQ-010 inst_ready  input  1  execute stage consumes inst this cycle.
REQ-011 count  output  4  number of complete instructions in the FIFO, 0..DEPTH.
REQ-012 issued  output  8  number of instructions consumed by the execute stage; wraps modulo 256.

Function
REQ-013 A byte transfer occurs on a rising edge with byte_valid=1 and byte_ready=1; an issue occurs on a rising edge with inst_valid=1 and inst_ready=1.
REQ-014 Assembly FSM, two states:
  - PH_LO: a byte transfer stores byte_in into the low-byte holding register and moves to PH_HI.
  - PH_HI: a byte transfer pushes {byte_in, held_lo} into the FIFO tail and moves to PH_LO.
REQ-015 byte_ready = !(state==PH_HI && count==DEPTH); combinational; does not depend on inst_ready.
REQ-016 In PH_LO, byte_ready=1 even when the FIFO is full.
REQ-017 inst_valid = (count != 0); inst = FIFO head entry (show-ahead); inst holds stable while inst_valid=1 and inst_ready=0.
REQ-018 Latency: a high-byte transfer at edge N into an empty FIFO gives inst_valid=1 with the new word after edge N (visible in cycle N+1).
REQ-019 A push and an issue on the same edge with 0<count<DEPTH leave count unchanged and preserve FIFO order.
REQ-020 inst_ready with count==0 is ignored: no pointer or issued change.
REQ-021 Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0.
REQ-022 issued increments by 1 per issue; 255 wraps to 0.
REQ-023 flush=1 on an edge:
  - count and pointers go to 0 and the FSM goes to PH_LO;
  - any byte or issue transfer in that cycle is discarded and does not increment issued;
  - flush has priority over all other events.
REQ-024 issued is not cleared by flush.

Reset
REQ-025 rst=1 on an edge sets state=PH_LO, count=0, pointers=0, held_lo=0, issued=0; rst has priority over flush and all transfers.
REQ-026 During and after reset: inst_valid=0, byte_ready=1, count=0, issued=0; FIFO storage contents need not be reset.
REQ-027 rst asserted mid-assembly (PH_HI) discards the held low byte; the next byte after reset is treated as a low byte.

Verification
REQ-028 Reset, then bytes 0x1B, 0x64 with inst_ready=0 -> inst=0x641B, inst_valid=1, count=1 one cycle after the second byte.
REQ-029 Fill with DEPTH=4 words 0x0001..0x0004, then one extra low byte 0xAA -> byte_ready=1 in PH_LO, byte_ready=0 in PH_HI; count stays 4 until inst_ready=1.
REQ-030 count=2, inst_ready=1 and a high-byte transfer on the same edge -> count stays 2; the issued sequence preserves push order.
REQ-031 Send low byte 0x55, then flush=1 with byte_valid=1 -> count=0, state PH_LO; next bytes 0x03, 0x00 yield inst=0x0003.
REQ-032 Issue 257 instructions back-to-back -> issued=0x01, with no bubble between instructions while the FIFO is non-empty.
REQ-033 Assert rst while in PH_HI with count=3 -> inst_valid=0, count=0, issued=0; next bytes 0x11, 0x22 yield inst=0x2211.
